store_buffer_controller: RTL and testbench

Store-side companion to the data-memory load path: accepts SB/SH/SW requests from the memory stage, converts them into word-aligned address, lane-shifted data and 4-bit byte enables, and queues them in a small FIFO. A drain state machine writes entries to main memory over a req/ack handshake while the pipeline keeps running. Pending stores are exposed to the load path through a word-address hazard flag, so loads never return stale data.

---
 rtl/store_buffer_controller.sv | 105 ++++++++++
 tb/tb_store_buffer_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_controller.sv
// store_buffer_controller: aligns SB/SH/SW stores into a FIFO drained over req/ack, with load-hazard detection.
// Define STORE_MERGE_EN to merge a store into the newest entry when word addresses match.
module store_buffer_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iStoreValid,
  input  logic [1:0]            iStoreType,
  input  logic [DATA_WIDTH-1:0] iAddress,
  input  logic [DATA_WIDTH-1:0] iStoreData,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oMisaligned,
  input  logic [DATA_WIDTH-1:0] iLoadAddress,
  output logic                  oLoadHazard,
  output logic                  oMemReq,
  input  logic                  iMemAck,
  output logic [DATA_WIDTH-1:0] oMemAddress,
  output logic [DATA_WIDTH-1:0] oMemData,
  output logic [3:0]            oMemByteEn
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, REQ} state_t;
  state_t r_state, w_state_nx;
  logic [PW-1:0] r_head, r_tail, w_off;
  logic [CW-1:0] r_count, w_count_nx;
  logic [DATA_WIDTH-3:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [3:0] r_be [DEPTH];
  logic r_mis;
  logic w_is_b, w_is_h, w_aligned, w_push, w_pop, w_merge, w_unused;
  logic [3:0] w_be;
  logic [DATA_WIDTH-1:0] w_data;
  assign w_is_b    = iStoreType == 2'b00;
  assign w_is_h    = iStoreType == 2'b01;
  assign w_aligned = w_is_b | (w_is_h ? ~iAddress[0] : iAddress[1:0] == 2'b00);
  assign w_be      = w_is_b ? 4'b0001 << iAddress[1:0] : w_is_h ? (iAddress[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_data    = w_is_b ? {4{iStoreData[7:0]}} : w_is_h ? {2{iStoreData[15:0]}} : iStoreData;
  assign w_unused  = ^iLoadAddress[1:0];
`ifdef STORE_MERGE_EN
  logic [PW-1:0] w_newest;
  assign w_newest = r_tail - PW'(1);
  // the head may only absorb a merge before its request goes out
  assign w_merge = iStoreValid && w_aligned && r_count != '0 &&
                   r_addr[w_newest] == iAddress[DATA_WIDTH-1:2] &&
                   !(w_newest == r_head && r_state == REQ);
`else
  assign w_merge = 1'b0;
`endif
  assign w_push     = iStoreValid && w_aligned && !w_merge && r_count != CW'(DEPTH);
  assign w_pop      = r_state == REQ && iMemAck;
  assign w_count_nx = r_count + CW'(w_push) - CW'(w_pop);
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= w_count_nx;
      r_mis   <= iStoreValid && !w_aligned;
    end
  end
  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_addr[r_tail] <= iAddress[DATA_WIDTH-1:2];
      r_data[r_tail] <= w_data;
      r_be[r_tail]   <= w_be;
    end
`ifdef STORE_MERGE_EN
    if (w_merge) begin
      r_be[w_newest] <= r_be[w_newest] | w_be;
      for (int n = 0; n < 4; n++) if (w_be[n]) r_data[w_newest][8*n +: 8] <= w_data[8*n +: 8];
    end
`endif
  end
  always_comb begin
    w_state_nx = r_state == IDLE ? (r_count != '0 ? REQ : IDLE) : (w_count_nx != '0 ? REQ : IDLE);
  end
  // head fields are gated so idle and reset both present zeros
  always_comb begin
    oMemReq     = r_state == REQ;
    oMemAddress = r_state == REQ ? {r_addr[r_head], 2'b00} : '0;
    oMemData    = r_state == REQ ? r_data[r_head] : '0;
    oMemByteEn  = r_state == REQ ? r_be[r_head] : '0;
  end
  always_comb begin
    oLoadHazard = 1'b0;
    w_off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = PW'(i) - r_head;
      if ({1'b0, w_off} < r_count && r_addr[i] == iLoadAddress[DATA_WIDTH-1:2]) oLoadHazard = 1'b1;
    end
  end
  assign oFull       = r_count == CW'(DEPTH);
  assign oEmpty      = r_count == '0 && r_state == IDLE;
  assign oMisaligned = r_mis;
endmodule

// File: tb/tb_store_buffer_controller.sv
// tb_store_buffer_controller: vector table, directed corner sequences and a queue-model random run.
module tb_store_buffer_controller;
  localparam int DEPTH = 4;
  localparam int NV = 10;
  logic iClk = 0, iRstN = 0, iStoreValid = 0, iMemAck = 0;
  logic [1:0] iStoreType = 0;
  logic [31:0] iAddress = 0, iStoreData = 0, iLoadAddress = 0;
  logic oFull, oEmpty, oMisaligned, oLoadHazard, oMemReq;
  logic [31:0] oMemAddress, oMemData;
  logic [3:0] oMemByteEn;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [1:0] t; logic [31:0] a, d, ea, ed; logic [3:0] eb; logic em;
  } vec_t;
  typedef struct { logic [29:0] wa; logic [31:0] d; logic [3:0] be; } ent_t;
  vec_t v [NV];
  ent_t q [$];
  ent_t e;
  bit m_req, m_mis, ok, pop, psh, mrg, exp_hz;
  logic [3:0] m_be;
  logic [31:0] m_d;
  int was;

  always #5 iClk = ~iClk;

  store_buffer_controller #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStoreValid(iStoreValid), .iStoreType(iStoreType),
    .iAddress(iAddress), .iStoreData(iStoreData), .oFull(oFull), .oEmpty(oEmpty),
    .oMisaligned(oMisaligned), .iLoadAddress(iLoadAddress), .oLoadHazard(oLoadHazard),
    .oMemReq(oMemReq), .iMemAck(iMemAck), .oMemAddress(oMemAddress), .oMemData(oMemData),
    .oMemByteEn(oMemByteEn)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    iStoreValid = 1; iStoreType = t; iAddress = a; iStoreData = d;
    step();
    iStoreValid = 0;
  endtask

  task automatic do_reset();
    iRstN = 0; iMemAck = 0; iStoreValid = 0;
    step();
    iRstN = 1;
    step();
  endtask

  // reference alignment from access size: aligned iff addr is a multiple of the size
  function automatic void align(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                output bit aok, output logic [3:0] be, output logic [31:0] dd);
    int sz;
    sz  = (t == 0) ? 1 : (t == 1) ? 2 : 4;
    aok = (a % sz) == 0;
    be  = 4'(((1 << sz) - 1) << (a % 4));
    for (int k = 0; k < 4; k++) dd[8*k +: 8] = 8'(d >> (8 * (k % sz)));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    v[0] = '{2'b00, 32'h1003, 32'h000000A5, 32'h1000, 32'hA5A5A5A5, 4'b1000, 1'b0};
    v[1] = '{2'b00, 32'h1000, 32'h12345678, 32'h1000, 32'h78787878, 4'b0001, 1'b0};
    v[2] = '{2'b01, 32'h2002, 32'hDEADBEEF, 32'h2000, 32'hBEEFBEEF, 4'b1100, 1'b0};
    v[3] = '{2'b01, 32'h2000, 32'h0000CAFE, 32'h2000, 32'hCAFECAFE, 4'b0011, 1'b0};
    v[4] = '{2'b10, 32'h3004, 32'h89ABCDEF, 32'h3004, 32'h89ABCDEF, 4'b1111, 1'b0};
    v[5] = '{2'b11, 32'h3008, 32'h01020304, 32'h3008, 32'h01020304, 4'b1111, 1'b0};
    v[6] = '{2'b01, 32'h2001, 32'h00001234, 32'h0,    32'h0,        4'b0000, 1'b1};
    v[7] = '{2'b10, 32'h2002, 32'h55667788, 32'h0,    32'h0,        4'b0000, 1'b1};
    v[8] = '{2'b11, 32'h2001, 32'h55667788, 32'h0,    32'h0,        4'b0000, 1'b1};
    v[9] = '{2'b00, 32'h0005, 32'h000000FF, 32'h0004, 32'hFFFFFFFF, 4'b0010, 1'b0};

    @(negedge iClk);
    step();
    check("rst_req", oMemReq, 0);
    check("rst_addr", oMemAddress, 0);
    check("rst_be", oMemByteEn, 0);
    check("rst_full", oFull, 0);
    check("rst_empty", oEmpty, 1);
    check("rst_mis", oMisaligned, 0);
    iRstN = 1;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(v[i].t, v[i].a, v[i].d);
      check($sformatf("vec%0d_mis", i), oMisaligned, v[i].em);
      check($sformatf("vec%0d_req_early", i), oMemReq, 0);
      if (!v[i].em) begin
        step();
        check($sformatf("vec%0d_req", i), oMemReq, 1);
        check($sformatf("vec%0d_addr", i), oMemAddress, v[i].ea);
        check($sformatf("vec%0d_data", i), oMemData, v[i].ed);
        check($sformatf("vec%0d_be", i), oMemByteEn, v[i].eb);
        iMemAck = 1;
        step();
        iMemAck = 0;
      end else step();
      check($sformatf("vec%0d_empty", i), oEmpty, 1);
      check($sformatf("vec%0d_mis_clr", i), oMisaligned, 0);
    end

    // fill then back-to-back drain
    do_reset();
    for (int k = 0; k < 4; k++) drive(2'b10, 32'(4 * k), 32'(k + 1));
    check("fill_full", oFull, 1);
    drive(2'b10, 32'h10, 32'h99);
    check("fill_full_after_5th", oFull, 1);
    iMemAck = 1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_req", k), oMemReq, 1);
      check($sformatf("drain%0d_addr", k), oMemAddress, 32'(4 * k));
      check($sformatf("drain%0d_data", k), oMemData, 32'(k + 1));
      step();
      if (k == 0) check("drain_full_drop", oFull, 0);
    end
    iMemAck = 0;
    check("drain_done_req", oMemReq, 0);
    check("drain_done_empty", oEmpty, 1);

    // back-to-back misaligned requests
    iStoreValid = 1; iStoreType = 2'b01; iAddress = 32'h2001;
    step();
    check("mis1_pulse", oMisaligned, 1);
    iStoreType = 2'b10; iAddress = 32'h2002;
    step();
    iStoreValid = 0;
    check("mis2_pulse", oMisaligned, 1);
    check("mis2_req", oMemReq, 0);
    step();
    check("mis_end", oMisaligned, 0);
    check("mis_empty", oEmpty, 1);
    check("mis_req", oMemReq, 0);

    // load hazard
    drive(2'b10, 32'h3008, 32'hAAAA5555);
    iLoadAddress = 32'h300B; #1;
    check("hz_match", oLoadHazard, 1);
    iLoadAddress = 32'h300C; #1;
    check("hz_miss", oLoadHazard, 0);
    step();
    iLoadAddress = 32'h3008; #1;
    check("hz_head_draining", oLoadHazard, 1);
    iMemAck = 1;
    step();
    iMemAck = 0; #1;
    check("hz_after_pop", oLoadHazard, 0);

    // reset mid-drain
    do_reset();
    for (int k = 0; k < 3; k++) drive(2'b10, 32'(32'h500 + 4 * k), 32'(k));
    for (int w = 0; w < 10 && !oMemReq; w++) step();
    check("rmd_req_before", oMemReq, 1);
    #2 iRstN = 0;
    #1;
    check("rmd_req", oMemReq, 0);
    check("rmd_addr", oMemAddress, 0);
    check("rmd_data", oMemData, 0);
    check("rmd_be", oMemByteEn, 0);
    check("rmd_full", oFull, 0);
    check("rmd_empty", oEmpty, 1);
    check("rmd_mis", oMisaligned, 0);
    @(negedge iClk);
    step();
    iRstN = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rmd_post%0d_req", k), oMemReq, 0);
    end

    // merge behaviour on consecutive byte stores to one word
    do_reset();
    drive(2'b00, 32'h40, 32'h11);
    drive(2'b00, 32'h41, 32'h22);
    check("mrg_req", oMemReq, 1);
`ifdef STORE_MERGE_EN
    check("mrg_be", oMemByteEn, 4'b0011);
    check("mrg_data", oMemData[15:0], 16'h2211);
    iMemAck = 1;
    step();
    iMemAck = 0;
`else
    check("nomrg_be0", oMemByteEn, 4'b0001);
    check("nomrg_data0", oMemData[15:0], 16'h1111);
    iMemAck = 1;
    step();
    check("nomrg_req1", oMemReq, 1);
    check("nomrg_be1", oMemByteEn, 4'b0010);
    check("nomrg_data1", oMemData[15:0], 16'h2222);
    step();
    iMemAck = 0;
`endif
    check("mrg_empty", oEmpty, 1);

    // randomized run against the queue model
    do_reset();
    q.delete();
    m_req = 0; m_mis = 0;
    repeat (600) begin
      iStoreValid  = $urandom_range(0, 9) < 6;
      iStoreType   = 2'($urandom_range(0, 3));
      iAddress     = 32'h100 + 4 * $urandom_range(0, 5) + $urandom_range(0, 3);
      iStoreData   = $urandom;
      iMemAck      = $urandom_range(0, 1) == 1;
      iLoadAddress = 32'h100 + $urandom_range(0, 27);
      #1;
      exp_hz = 0;
      foreach (q[j]) if (q[j].wa == iLoadAddress[31:2]) exp_hz = 1;
      check("rnd_full", oFull, 32'(q.size() == DEPTH));
      check("rnd_empty", oEmpty, 32'(q.size() == 0 && !m_req));
      check("rnd_req", oMemReq, 32'(m_req));
      check("rnd_mis", oMisaligned, 32'(m_mis));
      check("rnd_hazard", oLoadHazard, 32'(exp_hz));
      if (m_req && q.size() > 0) begin
        check("rnd_addr", oMemAddress, {q[0].wa, 2'b00});
        check("rnd_data", oMemData, q[0].d);
        check("rnd_be", oMemByteEn, q[0].be);
      end
      align(iStoreType, iAddress, iStoreData, ok, m_be, m_d);
      pop = m_req && iMemAck;
      mrg = 0;
`ifdef STORE_MERGE_EN
      mrg = iStoreValid && ok && q.size() > 0 && q[q.size()-1].wa == iAddress[31:2] && !(q.size() == 1 && m_req);
`endif
      psh = iStoreValid && ok && !mrg && q.size() < DEPTH;
      was = q.size();
      if (mrg) begin
        e = q[q.size()-1];
        for (int k = 0; k < 4; k++) if (m_be[k]) e.d[8*k +: 8] = m_d[8*k +: 8];
        e.be = e.be | m_be;
        q[q.size()-1] = e;
      end
      if (pop) void'(q.pop_front());
      if (psh) q.push_back('{iAddress[31:2], m_d, m_be});
      m_req = m_req ? q.size() != 0 : was != 0;
      m_mis = iStoreValid && !ok;
      @(posedge iClk);
      @(negedge iClk);
    end
    iStoreValid = 0; iMemAck = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
